// File: rtl/mcm_pkg.sv
// Shared widths and the round-robin search used by the channel merger.
package mcm_pkg;

    localparam int MAX_CH = 16;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } grant_t;

    // Channel-tag width: at least one bit even for a single-bit index.
    function automatic int ch_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Scans from last+num_ch down to last+1 so the nearest requester after last wins.
    function automatic grant_t rr_next(input logic [MAX_CH-1:0] req,
                                       input logic [3:0]        last,
                                       input int                num_ch);
        grant_t     g;
        int         cand;
        logic [3:0] c4;
        g = '0;
        for (int off = MAX_CH; off >= 1; off--) begin
            if (off <= num_ch) begin
                cand = (int'(last) + off) % num_ch;
                c4   = cand[3:0];
                if (req[c4]) begin
                    g.found = 1'b1;
                    g.idx   = c4;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/mcm_sync_fifo.sv
// Per-channel synchronous FIFO with a combinational head word.
module mcm_sync_fifo
    import mcm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count;
    logic             do_wr;
    logic             do_rd;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;
    assign dout  = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers wrap naturally; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count      <= '0;
        end else begin
            if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/multi_channel_merge.sv
// Merges NUM_CH buffered channel streams into one tagged valid/ready stream, round-robin.
module multi_channel_merge
    import mcm_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 8,
    parameter int NUM_CH  = 2,
    parameter int BP_MODE = 1,
    localparam int CH_W   = ch_w(NUM_CH)
) (
    input  logic                    clk_slow,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       ch_valid,
    output logic [NUM_CH-1:0]       ch_ready,
    input  logic [NUM_CH*WIDTH-1:0] ch_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]         out_ch,
    output logic [NUM_CH-1:0]       ch_ovf,
    input  logic                    ovf_clr
);

    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] wr_en;
    logic [NUM_CH-1:0] rd_en;
    logic [WIDTH-1:0]  head [NUM_CH];

    logic [MAX_CH-1:0] req;
    grant_t            grant;
    logic [CH_W-1:0]   grant_ch;
    logic              load;

    logic [3:0]        rr_last_reg;
    logic              out_valid_reg;
    logic [WIDTH-1:0]  out_data_reg;
    logic [CH_W-1:0]   out_ch_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : gen_ch
            // Full is sampled before the edge, so a same-cycle pop never frees room for a write.
            assign wr_en[gi]    = ch_valid[gi] && !full[gi];
            assign rd_en[gi]    = load && (grant.idx == 4'(gi));
            assign ch_ready[gi] = rst_n && ((BP_MODE == 0) || !full[gi]);

            mcm_sync_fifo #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk   (clk_slow),
                .rst_n (rst_n),
                .wr_en (wr_en[gi]),
                .rd_en (rd_en[gi]),
                .din   (ch_data[gi*WIDTH +: WIDTH]),
                .dout  (head[gi]),
                .full  (full[gi]),
                .empty (empty[gi])
            );
        end
    endgenerate

    always_comb begin
        req               = '0;
        req[NUM_CH-1:0]   = ~empty;
    end

    assign grant    = rr_next(req, rr_last_reg, NUM_CH);
    assign grant_ch = grant.idx[CH_W-1:0];
    assign load     = (!out_valid_reg || out_ready) && grant.found;

    always_ff @(posedge clk_slow or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_reg   <= 4'(NUM_CH - 1);
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_ch_reg    <= '0;
        end else begin
            if (load) begin
                rr_last_reg   <= grant.idx;
                out_valid_reg <= 1'b1;
                out_data_reg  <= head[grant_ch];
                out_ch_reg    <= grant_ch;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_ch    = out_ch_reg;

    generate
        if (BP_MODE == 0) begin : gen_ovf
            logic [NUM_CH-1:0] ovf_reg;
            // A drop in the same cycle as a clear leaves the flag set.
            always_ff @(posedge clk_slow or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_reg <= '0;
                end else begin
                    ovf_reg <= (ovf_clr ? '0 : ovf_reg) | (ch_valid & full);
                end
            end
            assign ch_ovf = ovf_reg;
        end else begin : gen_no_ovf
            assign ch_ovf = '0;
        end
    endgenerate

endmodule

// File: tb/tb_multi_channel_merge.sv
// Directed bench for multi_channel_merge: backpressure instance plus a drop-mode instance.
module tb_multi_channel_merge;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [1:0]  ch_valid, ch_ready, ch_ovf;
    logic [15:0] ch_data;
    logic        out_valid, out_ready, ovf_clr;
    logic [7:0]  out_data;
    logic [0:0]  out_ch;

    logic [1:0]  ch_valid_d, ch_ready_d, ch_ovf_d;
    logic [15:0] ch_data_d;
    logic        out_valid_d, out_ready_d, ovf_clr_d;
    logic [7:0]  out_data_d;
    logic [0:0]  out_ch_d;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    multi_channel_merge #(.WIDTH(8), .DEPTH(8), .NUM_CH(2), .BP_MODE(1)) dut_bp (
        .clk_slow (clk),      .rst_n    (rst_n),
        .ch_valid (ch_valid), .ch_ready (ch_ready), .ch_data (ch_data),
        .out_valid(out_valid),.out_ready(out_ready),.out_data(out_data),
        .out_ch   (out_ch),   .ch_ovf   (ch_ovf),   .ovf_clr (ovf_clr)
    );

    multi_channel_merge #(.WIDTH(8), .DEPTH(8), .NUM_CH(2), .BP_MODE(0)) dut_drop (
        .clk_slow (clk),        .rst_n    (rst_n),
        .ch_valid (ch_valid_d), .ch_ready (ch_ready_d), .ch_data (ch_data_d),
        .out_valid(out_valid_d),.out_ready(out_ready_d),.out_data(out_data_d),
        .out_ch   (out_ch_d),   .ch_ovf   (ch_ovf_d),   .ovf_clr (ovf_clr_d)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        ch_valid = 2'b11; ch_data = 16'h5A5A; out_ready = 1'b0; ovf_clr = 1'b0;
        ch_valid_d = 2'b11; ch_data_d = 16'hA5A5; out_ready_d = 1'b0; ovf_clr_d = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (ch_ready !== 2'b00) begin fails++; $display("FAIL reset_ch_ready got %b exp 00", ch_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        tests++; if (out_data !== 8'h00 || out_ch !== 1'b0) begin fails++; $display("FAIL reset_out_regs got %h/%b exp 00/0", out_data, out_ch); end
        tests++; if (ch_ready_d !== 2'b00 || ch_ovf_d !== 2'b00) begin fails++; $display("FAIL reset_drop got ready %b ovf %b exp 00 00", ch_ready_d, ch_ovf_d); end
        rst_n = 1'b1; ch_valid = 2'b00; ch_valid_d = 2'b00;
        #1;
        tests++; if (ch_ready !== 2'b11 || ch_ready_d !== 2'b11) begin fails++; $display("FAIL release_ch_ready got %b %b exp 11 11", ch_ready, ch_ready_d); end
        $display("[TB] reset: done");
    endtask

    task automatic test_fairness();
        logic [7:0] exp_d [8];
        logic       exp_c [8];
        int idx = 0;
        int k = 0;
        for (int j = 0; j < 4; j++) begin
            exp_d[2*j] = 8'(8'hA0 + j);   exp_c[2*j] = 1'b0;
            exp_d[2*j+1] = 8'(8'hB0 + j); exp_c[2*j+1] = 1'b1;
        end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                tests++;
                if (idx >= 8) begin
                    fails++; $display("FAIL fair_extra got %h exp none", out_data);
                end else if (out_data !== exp_d[idx] || out_ch !== exp_c[idx]) begin
                    fails++; $display("FAIL fair_word%0d got %h/ch%0d exp %h/ch%0d", idx, out_data, out_ch, exp_d[idx], exp_c[idx]);
                end
                idx++;
            end
            if (k < 4) begin
                ch_valid = 2'b11;
                ch_data  = {8'(8'hB0 + k), 8'(8'hA0 + k)};
                if (ch_ready == 2'b11) k++;
            end else begin
                ch_valid = 2'b00;
            end
        end
        tests++; if (idx !== 8) begin fails++; $display("FAIL fair_count got %0d exp 8", idx); end
        $display("[TB] fairness: %0d words", idx);
    endtask

    task automatic test_backpressure();
        int idx = 0;
        out_ready = 1'b0;
        // One word goes to the output register, eight fill the FIFO, the tenth is refused.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            ch_valid = 2'b01;
            ch_data  = {8'h00, 8'(8'h10 + k)};
            tests++;
            if (ch_ready[0] !== (k < 9)) begin
                fails++; $display("FAIL bp_ready_word%0d got %b exp %b", k, ch_ready[0], (k < 9));
            end
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests++;
            if (ch_ready !== 2'b10 || out_valid !== 1'b1 || out_data !== 8'h10 || out_ch !== 1'b0) begin
                fails++; $display("FAIL bp_hold got ready %b v %b d %h exp 10 1 10", ch_ready, out_valid, out_data);
            end
        end
        @(negedge clk);
        ch_valid = 2'b00; out_ready = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (out_valid) begin
                tests++;
                if (out_data !== 8'(8'h10 + idx) || out_ch !== 1'b0) begin
                    fails++; $display("FAIL bp_drain%0d got %h exp %h", idx, out_data, 8'(8'h10 + idx));
                end
                idx++;
            end
        end
        tests++; if (idx !== 9) begin fails++; $display("FAIL bp_drain_count got %0d exp 9", idx); end
        $display("[TB] backpressure: drained %0d", idx);
    endtask

    task automatic test_drop();
        int idx = 0;
        out_ready_d = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            ch_valid_d = 2'b10;
            ch_data_d  = {8'(8'h20 + k), 8'h00};
            tests++;
            if (ch_ready_d !== 2'b11 || ch_ovf_d !== 2'b00) begin
                fails++; $display("FAIL drop_pre%0d got ready %b ovf %b exp 11 00", k, ch_ready_d, ch_ovf_d);
            end
        end
        @(negedge clk);
        ch_valid_d = 2'b00;
        tests++; if (ch_ovf_d !== 2'b10) begin fails++; $display("FAIL drop_ovf_set got %b exp 10", ch_ovf_d); end
        tests++;
        if (out_valid_d !== 1'b1 || out_data_d !== 8'h20 || out_ch_d !== 1'b1) begin
            fails++; $display("FAIL drop_outreg got v %b d %h ch %b exp 1 20 1", out_valid_d, out_data_d, out_ch_d);
        end
        ovf_clr_d = 1'b1;
        @(negedge clk);
        tests++; if (ch_ovf_d !== 2'b00) begin fails++; $display("FAIL drop_ovf_clr got %b exp 00", ch_ovf_d); end
        ch_valid_d = 2'b10; ch_data_d = 16'h9900;
        @(negedge clk);
        tests++; if (ch_ovf_d !== 2'b10) begin fails++; $display("FAIL drop_set_wins got %b exp 10", ch_ovf_d); end
        ch_valid_d = 2'b00;
        @(negedge clk);
        ovf_clr_d = 1'b0; out_ready_d = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (out_valid_d) begin
                tests++;
                if (out_data_d !== 8'(8'h20 + idx) || out_ch_d !== 1'b1) begin
                    fails++; $display("FAIL drop_drain%0d got %h/ch%0d exp %h/ch1", idx, out_data_d, out_ch_d, 8'(8'h20 + idx));
                end
                idx++;
            end
        end
        tests++; if (idx !== 9) begin fails++; $display("FAIL drop_drain_count got %0d exp 9", idx); end
        $display("[TB] drop: drained %0d", idx);
    endtask

    task automatic test_wrap();
        logic [7:0] q [$];
        logic [7:0] w;
        int sent = 0;
        int got = 0;
        logic r;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (sent >= 24 && q.size() == 0 && !out_valid) break;
            @(negedge clk);
            r = 1'($urandom_range(0, 1));
            out_ready = r;
            if (out_valid && r) begin
                tests++;
                if (q.size() == 0) begin
                    fails++; $display("FAIL wrap_unexpected got %h exp none", out_data);
                end else begin
                    w = q.pop_front();
                    if (out_data !== w || out_ch !== 1'b0) begin
                        fails++; $display("FAIL wrap_word%0d got %h exp %h", got, out_data, w);
                    end
                end
                got++;
            end
            tests++;
            if (dut_bp.gen_ch[0].u_fifo.count > 4'd8) begin
                fails++; $display("FAIL wrap_count got %0d exp <=8", dut_bp.gen_ch[0].u_fifo.count);
            end
            if (sent < 24) begin
                ch_valid = 2'b01;
                ch_data  = {8'h00, 8'(8'h40 + sent)};
                if (ch_ready[0]) begin
                    q.push_back(8'(8'h40 + sent));
                    sent++;
                end
            end else begin
                ch_valid = 2'b00;
            end
        end
        tests++; if (got !== 24) begin fails++; $display("FAIL wrap_total got %0d exp 24", got); end
        $display("[TB] wrap: %0d words through ch0", got);
    endtask

    task automatic test_midop_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            ch_valid = 2'b01;
            ch_data  = {8'h00, 8'(8'h60 + k)};
        end
        @(negedge clk);
        ch_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || ch_ready !== 2'b00) begin
            fails++; $display("FAIL midrst_assert got v %b ready %b exp 0 00", out_valid, ch_ready);
        end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_idle%0d got %b exp 0", c, out_valid); end
        end
        ch_valid = 2'b01; ch_data = 16'h0077;
        @(negedge clk);
        ch_valid = 2'b00;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_latency got %b exp 0", out_valid); end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || out_data !== 8'h77 || out_ch !== 1'b0) begin
            fails++; $display("FAIL midrst_new got v %b d %h exp 1 77", out_valid, out_data);
        end
        $display("[TB] midop_reset: done");
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_backpressure();
        test_drop();
        test_wrap();
        test_midop_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
